// File: rtl/sync_fifo_reader_pkg.sv
// Shared sizing helpers for the chien_forney symbol buffer FIFO.
package sync_fifo_reader_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 16;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // One extra bit so a completely full FIFO is distinguishable from empty.
  function automatic int fifo_cnt_w(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_reader_if.sv
// Push/pop handshake bundle of the symbol buffer; slave is the FIFO, master the environment.
interface sync_fifo_reader_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
);
  logic                  flush_i;
  logic                  push_valid_i;
  logic                  push_ready_o;
  logic [DATA_WIDTH-1:0] push_data_i;
  logic                  pop_valid_o;
  logic                  pop_ready_i;
  logic [DATA_WIDTH-1:0] pop_data_o;
  logic [ADDR_WIDTH:0]   count_o;
  logic                  full_o;
  logic                  empty_o;

  modport slave (
    input  flush_i, push_valid_i, push_data_i, pop_ready_i,
    output push_ready_o, pop_valid_o, pop_data_o, count_o, full_o, empty_o
  );

  modport master (
    output flush_i, push_valid_i, push_data_i, pop_ready_i,
    input  push_ready_o, pop_valid_o, pop_data_o, count_o, full_o, empty_o
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Symbol storage array: registered write, combinational read, no reset on contents.
module sync_fifo_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] addr_out,
  output logic [DATA_WIDTH-1:0] data_out
);
  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[addr_in] <= data_in;
  end

  assign data_out = mem[addr_out];
endmodule

// File: rtl/sync_fifo_reader.sv
// Read-side controller for the symbol buffer: pointers, occupancy and a registered
// prefetch stage in front of the combinational-read RAM.
module sync_fifo_reader
  import sync_fifo_reader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic               clk_i,
  input logic               rst_ni,
  sync_fifo_reader_if.slave bus
);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam int CNT_W = fifo_cnt_w(ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_W-1:0]      ram_cnt;
  logic [CNT_W-1:0]      count;
  logic [DATA_WIDTH-1:0] pop_data_p1;
  logic                  vld_p1;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  full;
  logic                  push_accept;
  logic                  pop_accept;
  logic                  load;

  assign full        = (count == CNT_W'(DEPTH));
  assign push_accept = bus.push_valid_i && !full;
  assign pop_accept  = vld_p1 && bus.pop_ready_i;
  // Refill the output register whenever it is free or being emptied this cycle.
  assign load        = (ram_cnt != '0) && (!vld_p1 || bus.pop_ready_i);

  sync_fifo_ram #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_storage (
    .clk_i    (clk_i),
    .wr_en    (push_accept && !bus.flush_i),
    .addr_in  (wr_ptr),
    .data_in  (bus.push_data_i),
    .addr_out (rd_ptr),
    .data_out (ram_rdata)
  );

  // Stage p1: prefetched output word and occupancy bookkeeping
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      count       <= '0;
      vld_p1      <= 1'b0;
      pop_data_p1 <= '0;
    end else if (bus.flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      ram_cnt     <= '0;
      count       <= '0;
      vld_p1      <= 1'b0;
      pop_data_p1 <= '0;
    end else begin
      if (push_accept) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (load) begin
        rd_ptr      <= rd_ptr + ADDR_WIDTH'(1);
        pop_data_p1 <= ram_rdata;
        vld_p1      <= 1'b1;
      end else if (pop_accept) begin
        vld_p1      <= 1'b0;
      end
      case ({push_accept, load})
        2'b10:   ram_cnt <= ram_cnt + CNT_W'(1);
        2'b01:   ram_cnt <= ram_cnt - CNT_W'(1);
        default: ram_cnt <= ram_cnt;
      endcase
      case ({push_accept, pop_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign bus.push_ready_o = !full;
  assign bus.pop_valid_o  = vld_p1;
  assign bus.pop_data_o   = pop_data_p1;
  assign bus.count_o      = count;
  assign bus.full_o       = full;
  assign bus.empty_o      = (count == '0);
endmodule

// File: tb/tb_sync_fifo_reader.sv
// Directed bench for sync_fifo_reader: reset, fill/drain, latency, streaming,
// backpressure, full-with-pop, pointer wrap and flush.
module tb_sync_fifo_reader;
  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  sync_fifo_reader_if #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) bus ();

  sync_fifo_reader #(.ADDR_WIDTH(4), .DATA_WIDTH(16)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(bus.count_o), 32'd0);
    chk({tag, "_empty"}, 32'(bus.empty_o), 32'd1);
    chk({tag, "_full"}, 32'(bus.full_o), 32'd0);
    chk({tag, "_pvalid"}, 32'(bus.pop_valid_o), 32'd0);
    chk({tag, "_pdata"}, 32'(bus.pop_data_o), 32'd0);
    chk({tag, "_pready"}, 32'(bus.push_ready_o), 32'd1);
  endtask

  // Both sides always ready: n words pushed back to back, expected back in order,
  // first word out two edges after the first push and one word per cycle after that.
  task automatic stream(input string tag, input int n, input logic [15:0] base);
    int rcv = 0;
    int first = -1;
    int last = -1;
    int maxcnt = 0;
    bus.pop_ready_i = 1'b1;
    for (int cyc = 0; cyc < n + 8; cyc++) begin
      bus.push_valid_i = (cyc < n);
      bus.push_data_i  = base + 16'(cyc);
      if (bus.pop_valid_o) begin
        chk({tag, "_data"}, 32'(bus.pop_data_o), 32'(base + 16'(rcv)));
        if (first < 0) first = cyc;
        last = cyc;
        rcv++;
      end
      tick();
      if (int'(bus.count_o) > maxcnt) maxcnt = int'(bus.count_o);
    end
    bus.push_valid_i = 1'b0;
    chk({tag, "_words"}, 32'(rcv), 32'(n));
    chk({tag, "_first"}, 32'(first), 32'd2);
    chk({tag, "_last"}, 32'(last), 32'(n + 1));
    chk({tag, "_maxcnt"}, 32'(maxcnt), 32'd2);
    chk({tag, "_empty"}, 32'(bus.empty_o), 32'd1);
  endtask

  initial begin
    bus.flush_i      = 1'b0;
    bus.push_valid_i = 1'b0;
    bus.push_data_i  = '0;
    bus.pop_ready_i  = 1'b0;
    tick();
    tick();
    chk_reset_state("por");
    rst_ni = 1'b1;
    tick();

    // Fill to full with the consumer stalled
    for (int i = 1; i <= 16; i++) begin
      bus.push_valid_i = 1'b1;
      bus.push_data_i  = 16'(i);
      tick();
    end
    chk("fill_count", 32'(bus.count_o), 32'd16);
    chk("fill_full", 32'(bus.full_o), 32'd1);
    chk("fill_pready", 32'(bus.push_ready_o), 32'd0);
    chk("fill_head", 32'(bus.pop_data_o), 32'h0001);
    bus.push_data_i = 16'h00FF;
    tick();
    chk("refuse_count", 32'(bus.count_o), 32'd16);
    bus.push_valid_i = 1'b0;
    bus.pop_ready_i  = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain_valid", 32'(bus.pop_valid_o), 32'd1);
      chk("drain_data", 32'(bus.pop_data_o), 32'(i));
      tick();
    end
    chk("drain_empty", 32'(bus.empty_o), 32'd1);
    chk("drain_pvalid", 32'(bus.pop_valid_o), 32'd0);

    // Latency into an empty FIFO
    bus.pop_ready_i  = 1'b0;
    bus.push_valid_i = 1'b1;
    bus.push_data_i  = 16'hA5A5;
    tick();
    chk("lat_n_count", 32'(bus.count_o), 32'd1);
    chk("lat_n_pvalid", 32'(bus.pop_valid_o), 32'd0);
    bus.push_valid_i = 1'b0;
    tick();
    chk("lat_n1_pvalid", 32'(bus.pop_valid_o), 32'd1);
    chk("lat_n1_pdata", 32'(bus.pop_data_o), 32'hA5A5);

    // Backpressure: head word held while pushes pile up behind it
    for (int k = 0; k < 7; k++) begin
      bus.push_valid_i = 1'b1;
      bus.push_data_i  = 16'h0100 + 16'(k);
      tick();
      chk("bp_hold", 32'(bus.pop_data_o), 32'hA5A5);
      chk("bp_count", 32'(bus.count_o), 32'(2 + k));
    end
    bus.push_valid_i = 1'b0;
    bus.pop_ready_i  = 1'b1;
    chk("bp_head", 32'(bus.pop_data_o), 32'hA5A5);
    tick();
    for (int k = 0; k < 7; k++) begin
      chk("bp_drain", 32'(bus.pop_data_o), 32'h0100 + 32'(k));
      tick();
    end
    chk("bp_empty", 32'(bus.empty_o), 32'd1);

    stream("strm", 100, 16'h1000);

    // Full FIFO with a push and a pop in the same cycle
    bus.pop_ready_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.push_valid_i = 1'b1;
      bus.push_data_i  = 16'h2000 + 16'(i);
      tick();
    end
    chk("sim_full", 32'(bus.full_o), 32'd1);
    bus.push_data_i = 16'h3333;
    bus.pop_ready_i = 1'b1;
    tick();
    chk("sim_count15", 32'(bus.count_o), 32'd15);
    chk("sim_head", 32'(bus.pop_data_o), 32'h2001);
    bus.pop_ready_i = 1'b0;
    tick();
    chk("sim_count16", 32'(bus.count_o), 32'd16);
    bus.push_valid_i = 1'b0;
    bus.pop_ready_i  = 1'b1;
    for (int i = 1; i < 16; i++) begin
      chk("sim_drain", 32'(bus.pop_data_o), 32'h2000 + 32'(i));
      tick();
    end
    chk("sim_tail", 32'(bus.pop_data_o), 32'h3333);
    tick();
    chk("sim_empty", 32'(bus.empty_o), 32'd1);

    stream("wrap", 40, 16'h7000);

    // Flush with three words held and a push in the same cycle
    bus.pop_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.push_valid_i = 1'b1;
      bus.push_data_i  = 16'h4000 + 16'(i);
      tick();
    end
    chk("fl_pre_count", 32'(bus.count_o), 32'd3);
    bus.flush_i     = 1'b1;
    bus.push_data_i = 16'h4BAD;
    tick();
    chk_reset_state("flush");
    bus.flush_i      = 1'b0;
    bus.push_valid_i = 1'b0;
    tick();
    chk("fl_post_count", 32'(bus.count_o), 32'd0);
    chk("fl_post_pvalid", 32'(bus.pop_valid_o), 32'd0);
    bus.push_valid_i = 1'b1;
    bus.push_data_i  = 16'h5555;
    tick();
    bus.push_valid_i = 1'b0;
    tick();
    chk("fl_next_data", 32'(bus.pop_data_o), 32'h5555);
    chk("fl_next_count", 32'(bus.count_o), 32'd1);

    // Asynchronous reset with five words held
    for (int i = 0; i < 4; i++) begin
      bus.push_valid_i = 1'b1;
      bus.push_data_i  = 16'h6000 + 16'(i);
      tick();
    end
    bus.push_valid_i = 1'b0;
    chk("rst_pre_count", 32'(bus.count_o), 32'd5);
    rst_ni = 1'b0;
    #1;
    chk_reset_state("arst");
    tick();
    chk_reset_state("arst_clk");
    rst_ni = 1'b1;
    tick();
    chk("rst_after_count", 32'(bus.count_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_reader.md
Name: sync_fifo_reader

Overview:
Read-side controller and prefetch stage for the chien_forney symbol buffer. It wraps the existing sync_fifo_ram storage array (registered write, combinational read) and gives it a complete FIFO interface:
- write side: valid/ready push handshake that drives the RAM write port;
- read side: pointer, occupancy tracking and a registered valid/ready pop port that drains the RAM in order.

It buffers received codeword symbols until the Chien/Forney error values are ready to be combined with them.

Parameters:
- ADDR_WIDTH, 4, log2 of RAM depth; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 16, width of one stored word.

Ports:
- clk_i  input  1  single clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- flush_i  input  1  synchronous clear of all FIFO state.
- push_valid_i  input  1  push data valid.
- push_ready_o  output  1  push accepted when push_valid_i && push_ready_o.
- push_data_i  input  DATA_WIDTH  word to store.
- pop_valid_o  output  1  pop_data_o holds a valid word.
- pop_ready_i  input  1  consumer takes the word when pop_valid_o && pop_ready_i.
- pop_data_o  output  DATA_WIDTH  oldest word, registered.
- count_o  output  ADDR_WIDTH+1  total words held (RAM + output register), 0..DEPTH.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.

Behaviour:
- Reset (async assert, rst_ni low):
  - wr_ptr, rd_ptr, ram_cnt, count_o cleared to 0.
  - pop_valid_o = 0, pop_data_o = 0.
  - full_o = 0, empty_o = 1, push_ready_o = 1.
  - Reset mid-operation discards all content with no further handshakes.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0.
  - ram_cnt is ADDR_WIDTH+1 bits and counts words resident in the RAM.
- Push:
  - push_ready_o = !full_o, combinational from registered count.
  - On accept: RAM written at wr_ptr; wr_ptr increments.
  - Full FIFO: push is refused even if a pop occurs in the same cycle (no write-through when full).
- Prefetch:
  - load = (ram_cnt != 0) && (!pop_valid_o || pop_ready_i).
  - On load: pop_data_o <= RAM[rd_ptr]; rd_ptr increments; pop_valid_o <= 1.
- Pop:
  - If pop_valid_o && pop_ready_i and no load in that cycle, pop_valid_o <= 0.
  - pop_data_o is otherwise held unchanged.
  - With pop_valid_o = 1 and pop_ready_i = 0, pop_data_o is stable.
- Counters:
  - ram_cnt += push_accept - load.
  - count_o += push_accept - pop_accept.
  - Invariant: count_o = ram_cnt + pop_valid_o, always <= DEPTH.
- Latency:
  - A word accepted at edge N into an empty FIFO gives pop_valid_o = 1 after edge N+1.
  - There is no bypass path.
- Throughput:
  - Steady state sustains 1 push and 1 pop per cycle with pop_ready_i held high.
- RAM read/write same address:
  - Only possible when ram_cnt == 0, in which case no load occurs, so no hazard.
- Flush:
  - Same effect as reset, but on the clock edge.
  - Has priority over push and pop in the same cycle; that push is dropped.
  - RAM contents are not cleared.
- Pop when empty: no state change.

Decomposition:
- No shared typedefs are needed.
- The shared RS decoder package holds localparam helpers:
  - DEPTH = 1 << ADDR_WIDTH;
  - CNT_W = ADDR_WIDTH + 1.
- One sub-module: storage instance of sync_fifo_ram. Port mapping:
  - wr_en = push accept;
  - addr_in = wr_ptr;
  - addr_out = rd_ptr.
- All pointer, count and prefetch logic lives in this block.

Test Plan:
- Reset values: assert rst_ni low mid-stream with 5 words held -> next cycle count_o = 0, empty_o = 1, pop_valid_o = 0, pop_data_o = 0, push_ready_o = 1.
- Fill: push 0x0001..0x0010 with pop_ready_i = 0 -> full_o = 1, count_o = 16, push_ready_o = 0. A 17th push of 0x00FF is refused. Drain then yields 0x0001..0x0010 in order and empty_o = 1.
- Latency and streaming: push 0xA5A5 into empty FIFO at edge N -> pop_valid_o high after edge N+1. Streaming 100 words with both sides always ready gives 1 word/cycle, in order, and count_o never exceeds 2.
- Backpressure: pop_ready_i low for 7 cycles with pop_valid_o = 1 -> pop_data_o unchanged for all 7 cycles; count_o rises with pushes.
- Simultaneous events: full FIFO with push_valid_i = 1 and pop_ready_i = 1 -> one word popped, push refused, count_o = 15. Next cycle the push is accepted and count_o = 16.
- Wrap and flush: 40 push/pop cycles, checking pointer wrap with data intact. Then flush_i with push_valid_i = 1 and 3 words held -> count_o = 0, pop_valid_o = 0, and the pushed word is absent.
